// File: rtl/buzzer_ctrl_if.sv
// Slave-side CPU data-bus bundle for the buzzer peripheral: a single-cycle
// write strobe with address/data, and a read strobe whose data returns on
// the following cycle.
interface buzzer_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8
);
    logic                     wr;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [31:0]              wdata;
    logic                     rd;
    logic [ADDRESS_WIDTH-1:0] raddr;
    logic [31:0]              rdata;

    modport master (output wr, waddr, wdata, rd, raddr, input rdata);
    modport slave  (input wr, waddr, wdata, rd, raddr, output rdata);
endinterface

// File: rtl/buzzer_ctrl.sv
// Tone-generator peripheral. Software queues {duration, half-period} notes
// into a small FIFO; the sequencer plays them back-to-back as a square wave
// on buzzer_pin, with durations counted in prescaled ticks.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no note playing, buzzer_pin low; pops a note when EN=1
//   PLAY  | square wave (or rest) until the note's tick count expires
module buzzer_ctrl #(
    parameter int          ADDRESS_WIDTH = 8,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] DEFAULT_TICK  = 32'd50000
) (
    input  logic          clk,
    input  logic          rstn,
    buzzer_ctrl_if.slave  bus,
    output logic          buzzer_pin,
    output logic          busy
);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t      state;
    logic        en;
    logic        ovf;
    logic [31:0] tick;
    logic [31:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic [31:0] cur_note;
    logic [15:0] tone_cnt;
    logic [15:0] dur_cnt;
    logic [31:0] tick_cnt;

    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [ADDRESS_WIDTH-1:0] raddr;
    logic        unused_addr_bits;
    logic        wr_ctrl, wr_note, wr_tick, wr_stat;
    logic        flush, en_nxt, full, empty, start, push;
    logic [31:0] head;
    logic [31:0] tick_m1;
    logic [15:0] half;
    logic [31:0] status;

    // Only word offsets [3:2] are decoded; the rest of the window aliases.
    assign waddr            = bus.waddr;
    assign raddr            = bus.raddr;
    assign unused_addr_bits = ^{waddr[ADDRESS_WIDTH-1:4], waddr[1:0],
                                raddr[ADDRESS_WIDTH-1:4], raddr[1:0]};

    assign wr_ctrl = bus.wr && (waddr[3:2] == 2'd0);
    assign wr_note = bus.wr && (waddr[3:2] == 2'd1);
    assign wr_tick = bus.wr && (waddr[3:2] == 2'd2);
    assign wr_stat = bus.wr && (waddr[3:2] == 2'd3);

    // A CTRL write that clears EN (or flushes) aborts in the same edge, so
    // the FSM looks at the value EN is about to take.
    assign flush   = wr_ctrl && bus.wdata[1];
    assign en_nxt  = wr_ctrl ? bus.wdata[0] : en;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign start   = (state == IDLE) && en && en_nxt && !empty && !flush;
    assign push    = wr_note && (!full || start);
    assign head    = mem[rptr];
    assign tick_m1 = tick - 32'd1;
    assign half    = cur_note[15:0];
    assign status  = {24'd0, 4'(count), ovf, empty, full, busy};

    // Control registers: EN, TICK prescaler and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en   <= 1'b0;
            tick <= DEFAULT_TICK;
            ovf  <= 1'b0;
        end else begin
            if (wr_ctrl)
                en <= bus.wdata[0];
            if (wr_tick)
                tick <= (bus.wdata == 32'd0) ? 32'd1 : bus.wdata;
            if (wr_note && full && !start)
                ovf <= 1'b1;
            else if (wr_stat && bus.wdata[3])
                ovf <= 1'b0;
        end
    end

    // Note FIFO; a pop while full frees the slot the same-cycle push lands in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= bus.wdata;
                wptr      <= wptr + 1'b1;
            end
            if (start)
                rptr <= rptr + 1'b1;
            case ({push, start})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: loads a note, generates the tone and counts down its duration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            buzzer_pin <= 1'b0;
            cur_note   <= '0;
            tone_cnt   <= '0;
            dur_cnt    <= '0;
            tick_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    buzzer_pin <= 1'b0;
                    if (start) begin
                        cur_note <= head;
                        dur_cnt  <= head[31:16];
                        tone_cnt <= '0;
                        tick_cnt <= tick_m1;
                        state    <= PLAY;
                        busy     <= 1'b1;
                    end
                end
                PLAY: begin
                    if (flush || !en_nxt || (dur_cnt == 16'd0)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        buzzer_pin <= 1'b0;
                        cur_note   <= '0;
                    end else begin
                        // half == 0 is a rest: the pin simply never toggles
                        if (half != 16'd0) begin
                            if (tone_cnt == half - 16'd1) begin
                                tone_cnt   <= '0;
                                buzzer_pin <= ~buzzer_pin;
                            end else begin
                                tone_cnt <= tone_cnt + 16'd1;
                            end
                        end
                        // TICK is re-read at each reload, so rewrites apply then
                        if (tick_cnt == 32'd0) begin
                            tick_cnt <= tick_m1;
                            dur_cnt  <= dur_cnt - 16'd1;
                        end else begin
                            tick_cnt <= tick_cnt - 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; reads never disturb state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rdata <= '0;
        end else if (bus.rd) begin
            case (raddr[3:2])
                2'd0:    bus.rdata <= {31'd0, en};
                2'd1:    bus.rdata <= cur_note;
                2'd2:    bus.rdata <= tick;
                default: bus.rdata <= status;
            endcase
        end
    end
endmodule
